dm_byte_master: RTL

- Load/store initiator that sits between the single-cycle core's memory stage and a byte-wide data-memory port.
- Accepts one word, halfword or byte request over a valid/ready handshake.
- Serialises each request into little-endian byte accesses, one byte per cycle.
- Assembles and sign- or zero-extends load data, and returns a one-cycle response pulse.

---
 rtl/dm_byte_master_if.sv | 42 ++++
 rtl/dm_byte_master.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dm_byte_master_if.sv
// -----------------------------------------------------------------------------
// dm_byte_master_if
// Bundles the request/response handshake from the core's memory stage and the
// byte-wide data-memory port of dm_byte_master.
//   master modport : view of dm_byte_master (takes requests, drives memory)
//   slave  modport : view of the core + memory side (issues requests, serves
//                    byte reads/writes)
// Signals:
//   req_valid/req_ready/req_we/req_type/req_addr/req_wdata : request channel
//   resp_valid/resp_rdata/resp_err                         : response pulse
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata             : byte memory port
// -----------------------------------------------------------------------------
interface dm_byte_master_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_type;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport master (
        input  req_valid, req_we, req_type, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_type, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dm_byte_master.sv
// -----------------------------------------------------------------------------
// dm_byte_master
// Load/store initiator between a single-cycle core's memory stage and a
// byte-wide data memory. A word/halfword/byte request is serialised into
// little-endian byte accesses (one per cycle); load bytes are assembled and
// sign/zero-extended, and completion is signalled by a one-cycle pulse.
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset
//   bus  : dm_byte_master_if.master (request, response and memory signals)
// -----------------------------------------------------------------------------
module dm_byte_master #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 128
) (
    input  logic               clk,
    input  logic               rst,
    dm_byte_master_if.master   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    // Byte count for a request type; unsigned variants have the same size.
    function automatic logic [2:0] byte_count(input logic [2:0] t);
        logic [2:0] n;
        case (t)
            3'd0:    n = 3'd4;
            3'd1:    n = 3'd2;
            3'd2:    n = 3'd2;
            3'd3:    n = 3'd1;
            3'd4:    n = 3'd1;
            default: n = 3'd1;
        endcase
        return n;
    endfunction

    // Final load value from the assembled little-endian bytes.
    function automatic logic [31:0] extend_load(input logic [2:0] t, input logic [31:0] a);
        logic [31:0] v;
        case (t)
            3'd0:    v = a;
            3'd1:    v = {{16{a[15]}}, a[15:0]};
            3'd2:    v = {16'h0000, a[15:0]};
            3'd3:    v = {{24{a[7]}}, a[7:0]};
            3'd4:    v = {24'h00_0000, a[7:0]};
            default: v = 32'h0000_0000;
        endcase
        return v;
    endfunction

    state_t            r_state, w_state;
    logic              r_we, w_we;
    logic [2:0]        r_type, w_type;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [31:0]       r_wdata, w_wdata;
    logic [1:0]        r_last, w_last;
    logic [1:0]        r_k, w_k;
    logic [31:0]       r_asm, w_asm;
    logic              r_resp_valid, w_resp_valid;
    logic [31:0]       r_resp_rdata, w_resp_rdata;
    logic              r_resp_err, w_resp_err;
    logic              r_mem_en, w_mem_en;
    logic              r_mem_we, w_mem_we;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
    logic [7:0]        r_mem_wdata, w_mem_wdata;

    logic [2:0]        w_req_n;
    logic [ADDR_W:0]   w_req_end;
    logic              w_req_bad;
    logic [31:0]       w_merged;

    // Next-state and next-output decode for the request/transfer/response FSM.
    always_comb begin
        w_state      = r_state;
        w_we         = r_we;
        w_type       = r_type;
        w_addr       = r_addr;
        w_wdata      = r_wdata;
        w_last       = r_last;
        w_k          = r_k;
        w_asm        = r_asm;
        w_resp_valid = 1'b0;
        w_resp_rdata = 32'h0000_0000;
        w_resp_err   = 1'b0;
        w_mem_en     = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_addr   = r_mem_addr;
        w_mem_wdata  = r_mem_wdata;

        // Last byte address computed one bit wider so a request near the top
        // of the address space cannot wrap back into range.
        w_req_n   = byte_count(bus.req_type);
        w_req_end = {1'b0, bus.req_addr} + (ADDR_W+1)'(w_req_n) - (ADDR_W+1)'(1);
        w_req_bad = (bus.req_type > 3'd4) || (w_req_end >= DEPTH_L);

        // Byte arriving this cycle merged into lane k of the assembly word.
        w_merged = r_asm;
        w_merged[{r_k, 3'b000} +: 8] = bus.mem_rdata;

        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_we    = bus.req_we;
                    w_type  = bus.req_type;
                    w_addr  = bus.req_addr;
                    w_wdata = bus.req_wdata;
                    w_last  = 2'(w_req_n - 3'd1);
                    w_k     = 2'd0;
                    w_asm   = 32'h0000_0000;
                    if (w_req_bad) begin
                        w_state      = ST_RESP;
                        w_resp_valid = 1'b1;
                        w_resp_err   = 1'b1;
                    end else begin
                        w_state     = ST_XFER;
                        w_mem_en    = 1'b1;
                        w_mem_we    = bus.req_we;
                        w_mem_addr  = bus.req_addr;
                        w_mem_wdata = bus.req_wdata[7:0];
                    end
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_XFER: begin
                w_asm = w_merged;
                if (r_k == r_last) begin
                    w_state      = ST_RESP;
                    w_resp_valid = 1'b1;
                    w_resp_rdata = r_we ? 32'h0000_0000 : extend_load(r_type, w_merged);
                end else begin
                    w_k         = r_k + 2'd1;
                    w_mem_en    = 1'b1;
                    w_mem_we    = r_we;
                    w_mem_addr  = r_addr + ADDR_W'(w_k);
                    w_mem_wdata = r_wdata[{w_k, 3'b000} +: 8];
                end
            end
            ST_RESP: begin
                w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    // State, latched request and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_we         <= 1'b0;
            r_type       <= 3'd0;
            r_addr       <= '0;
            r_wdata      <= 32'h0000_0000;
            r_last       <= 2'd0;
            r_k          <= 2'd0;
            r_asm        <= 32'h0000_0000;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0000_0000;
            r_resp_err   <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 8'h00;
        end else begin
            r_state      <= w_state;
            r_we         <= w_we;
            r_type       <= w_type;
            r_addr       <= w_addr;
            r_wdata      <= w_wdata;
            r_last       <= w_last;
            r_k          <= w_k;
            r_asm        <= w_asm;
            r_resp_valid <= w_resp_valid;
            r_resp_rdata <= w_resp_rdata;
            r_resp_err   <= w_resp_err;
            r_mem_en     <= w_mem_en;
            r_mem_we     <= w_mem_we;
            r_mem_addr   <= w_mem_addr;
            r_mem_wdata  <= w_mem_wdata;
        end
    end

    // Ready is held low while reset is applied, even though state is IDLE.
    assign bus.req_ready  = (r_state == ST_IDLE) & ~rst;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;
    assign bus.mem_en     = r_mem_en;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;

endmodule
